// File: rtl/add_sub_multiword.sv
// -----------------------------------------------------------------------------
// add_sub_multiword
//
// Multi-precision add/subtract unit. A W-bit operation (W = WORD_WIDTH *
// WORD_COUNT) is carried out one WORD_WIDTH slice per clock, least significant
// slice first, with the carry chained through a register. One narrow adder does
// the work of a full W-bit adder, at the cost of several cycles per operation.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous reset, active-high, overrides every other input
//   valid_i      request valid (producer side)
//   ready_o      unit is idle and can accept a request
//   add_sub_i    0: A+B+carry_in   1: A-B-carry_in
//   carry_in_i   carry in for add, borrow in for subtract
//   A_i, B_i     W-bit operands, sampled only on the accepting edge
//   valid_o      result valid (consumer side)
//   ready_i      consumer accepts the result
//   sum_o        W-bit result, modulo 2^W
//   carry_out_o  carry out of bit W-1 (for subtract: 1 = no borrow)
//   overflow_o   two's-complement overflow of the W-bit result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its request until ready_o is seen; a request
// that arrives while the unit is busy is neither taken nor queued. Once
// valid_o is high, sum_o, carry_out_o and overflow_o stay unchanged until the
// consumer raises ready_i.
//
// Timing: the accepting edge moves the unit to RUN. Each of the next
// WORD_COUNT edges processes one slice; the edge that processes the last slice
// moves it to DONE. valid_o is registered and rises on the following edge, so
// it appears on the (WORD_COUNT+1)th edge after acceptance. During RUN, sum_o
// shows partially written slices while valid_o is low.
// -----------------------------------------------------------------------------
module add_sub_multiword #(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 4,
  localparam int W         = WORD_WIDTH * WORD_COUNT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         add_sub_i,
  input  logic         carry_in_i,
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] sum_o,
  output logic         carry_out_o,
  output logic         overflow_o
);

  // A counter width of at least one bit keeps WORD_COUNT=1 legal.
  localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  // Slice datapath
  int                    slice_base;
  logic [WORD_WIDTH-1:0] slice_a;
  logic [WORD_WIDTH-1:0] slice_b;
  logic [WORD_WIDTH-1:0] slice_s;
  logic                  slice_c;
  logic                  msb_cin;

  always_comb begin
    slice_base = int'(cnt_q) * WORD_WIDTH;
    slice_a    = a_q[slice_base +: WORD_WIDTH];
    // Subtraction adds the one's complement of B; the +1 comes in through the
    // initial chain carry.
    slice_b    = b_q[slice_base +: WORD_WIDTH] ^ {WORD_WIDTH{sub_q}};
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b}
                       + {{WORD_WIDTH{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the MSB sum bit:
    // s = a ^ b ^ cin  ->  cin = a ^ b ^ s.
    msb_cin    = slice_a[WORD_WIDTH-1] ^ slice_b[WORD_WIDTH-1]
               ^ slice_s[WORD_WIDTH-1];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    valid_d     = valid_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = A_i;
          b_d     = B_i;
          sub_d   = add_sub_i;
          // Add: chain starts at carry_in. Sub: A + ~B + (1 - borrow_in).
          carry_d = carry_in_i ^ add_sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[slice_base +: WORD_WIDTH] = slice_s;
        carry_d = slice_c;
        if (cnt_q == LAST_SLICE) begin
          carry_out_d = slice_c;
          overflow_d  = msb_cin ^ slice_c;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // First DONE cycle raises valid_o; afterwards wait for the consumer.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = valid_q;
  assign sum_o       = sum_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_add_sub_multiword.sv
// -----------------------------------------------------------------------------
// tb_add_sub_multiword
//
// Directed bench for add_sub_multiword with WORD_WIDTH=8, WORD_COUNT=4
// (32-bit operands). Expected sums, carries and overflow flags below are
// worked out by hand. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_add_sub_multiword;

  localparam int WW = 8;
  localparam int WC = 4;
  localparam int W  = WW * WC;

  logic         clk_i;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic         add_sub_i;
  logic         carry_in_i;
  logic [W-1:0] A_i;
  logic [W-1:0] B_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_out_o;
  logic         overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  add_sub_multiword #(
    .WORD_WIDTH(WW),
    .WORD_COUNT(WC)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .add_sub_i  (add_sub_i),
    .carry_in_i (carry_in_i),
    .A_i        (A_i),
    .B_i        (B_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_out_o(carry_out_o),
    .overflow_o (overflow_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request and hold it across one edge; the unit must be idle.
  // Afterwards the operand inputs are scrambled so a design that keeps
  // sampling them would produce a wrong result.
  task automatic start_op(input string tag, input logic sub, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_ready_before"}, 64'(ready_o), 64'd1);
    valid_i    = 1'b1;
    add_sub_i  = sub;
    carry_in_i = ci;
    A_i        = a;
    B_i        = b;
    tick();
    valid_i    = 1'b0;
    A_i        = $urandom();
    B_i        = $urandom();
    add_sub_i  = 1'($urandom_range(0, 1));
    carry_in_i = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, 64'(ready_o), 64'd0);
  endtask

  // Count edges after acceptance until valid_o; bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] exp_sum,
                              input logic exp_c, input logic exp_v);
    check({tag, "_valid"}, 64'(valid_o),     64'd1);
    check({tag, "_sum"},   64'(sum_o),       64'(exp_sum));
    check({tag, "_carry"}, 64'(carry_out_o), 64'(exp_c));
    check({tag, "_ovf"},   64'(overflow_o),  64'(exp_v));
  endtask

  // Complete operation with ready_i held high.
  task automatic run_op(input string tag, input logic sub, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_c,
                        input logic exp_v);
    int n;
    ready_i = 1'b1;
    start_op(tag, sub, ci, a, b);
    wait_valid(n);
    check({tag, "_latency"}, 64'(n), 64'(WC + 1));
    check_result(tag, exp_sum, exp_c, exp_v);
    tick();
    check({tag, "_valid_drop"}, 64'(valid_o), 64'd0);
    check({tag, "_ready_after"}, 64'(ready_o), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    add_sub_i  = 1'b0;
    carry_in_i = 1'b0;
    A_i        = '0;
    B_i        = '0;
    ready_i    = 1'b1;
    repeat (3) tick();
    // Request presented during reset must not be taken.
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    rst_i   = 1'b0;

    check("rst_ready", 64'(ready_o),     64'd1);
    check("rst_valid", 64'(valid_o),     64'd0);
    check("rst_sum",   64'(sum_o),       64'd0);
    check("rst_carry", 64'(carry_out_o), 64'd0);
    check("rst_ovf",   64'(overflow_o),  64'd0);

    //      tag        sub   ci    A             B             sum          c     v
    run_op("add_wrap", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf",  1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_brw",  1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("sub_ovf",  1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("sub_bin",  1'b1, 1'b1, 32'd10,       32'd3,        32'd6,        1'b1, 1'b0);
    run_op("add_cin",  1'b0, 1'b1, 32'h000000FF, 32'h00000001, 32'h00000101, 1'b0, 1'b0);
    run_op("add_mix",  1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0);
    run_op("sub_eq",   1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    run_op("add_neg",  1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);

    // ---- backpressure: result held for 10 cycles, requests ignored ----
    ready_i = 1'b0;
    start_op("bp", 1'b0, 1'b0, 32'h11111111, 32'h22222222);
    wait_valid(n);
    check("bp_latency", 64'(n), 64'(WC + 1));
    for (int i = 0; i < 10; i++) begin
      valid_i   = (i % 2) == 0;
      add_sub_i = 1'b1;
      A_i       = 32'hDEADBEEF;
      B_i       = 32'h01234567;
      check_result("bp_hold", 32'h33333333, 1'b0, 1'b0);
      check("bp_ready", 64'(ready_o), 64'd0);
      tick();
    end
    valid_i = 1'b0;
    check_result("bp_last", 32'h33333333, 1'b0, 1'b0);
    ready_i = 1'b1;
    tick();
    check("bp_release_valid", 64'(valid_o), 64'd0);
    check("bp_release_ready", 64'(ready_o), 64'd1);
    run_op("bp_next", 1'b1, 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0);

    // ---- reset while slice 2 is being processed ----
    start_op("rst_run", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();          // slice 0 done
    tick();          // slice 1 done; slice 2 in progress
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rr_ready", 64'(ready_o),     64'd1);
    check("rr_valid", 64'(valid_o),     64'd0);
    check("rr_sum",   64'(sum_o),       64'd0);
    check("rr_carry", 64'(carry_out_o), 64'd0);
    check("rr_ovf",   64'(overflow_o),  64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_o) n++;
      tick();
    end
    check("rr_no_valid", 64'(n), 64'd0);
    run_op("rr_next", 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound in case a wait is mis-handled.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
